// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan counter: active-low segment codes
// (abcdefg, a in bit 6) and the BCD nibble width.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic int bcd_width();
        return 32'sd4;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low abcdefg segment decoder; non-BCD
// codes decode to blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [bcd_width()-1:0] bcd,
    output seg_t                   seg
);

    // nibble to segment lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed common-anode
// 7-segment driver. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int STEP_CYC = 5000000,
    parameter int SCAN_CYC = 100000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  CLR,
    input  logic [DIGITS-1:0]     DP_MASK,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic                  WRAP,
    output logic [DIGITS+7:0]     DISP
);

    localparam int NW = bcd_width();
    localparam int SW = $clog2(STEP_CYC);
    localparam int CW = $clog2(SCAN_CYC);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0]        step_cnt_r;
    logic                 step_s;
    logic [NW*DIGITS-1:0] value_r;
    logic [NW*DIGITS-1:0] value_nx_s;
    logic                 carry_s;
    logic                 wrap_r;
    logic [CW-1:0]        scan_cnt_r;
    logic [IW-1:0]        idx_r;
    logic [NW-1:0]        nib_s;
    logic [DIGITS-1:0]    anode_s;
    logic                 dp_s;
    logic                 blank_s;
    seg_t                 dec_s;
    seg_t                 seg_s;
    logic [DIGITS+7:0]    disp_r;

    assign step_s = EN && (step_cnt_r == SW'(STEP_CYC - 1));

    // next BCD value: ripple carry (up) or borrow (down); carry out of the top digit means wrap
    always_comb begin
        value_nx_s = value_r;
        carry_s    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (UP) begin
                    if (value_r[i*NW +: NW] == 4'd9) begin
                        value_nx_s[i*NW +: NW] = 4'd0;
                        carry_s                = 1'b1;
                    end else begin
                        value_nx_s[i*NW +: NW] = value_r[i*NW +: NW] + 4'd1;
                        carry_s                = 1'b0;
                    end
                end else begin
                    if (value_r[i*NW +: NW] == 4'd0) begin
                        value_nx_s[i*NW +: NW] = 4'd9;
                        carry_s                = 1'b1;
                    end else begin
                        value_nx_s[i*NW +: NW] = value_r[i*NW +: NW] - 4'd1;
                        carry_s                = 1'b0;
                    end
                end
            end else begin
                value_nx_s[i*NW +: NW] = value_r[i*NW +: NW];
                carry_s                = 1'b0;
            end
        end
    end

    // step prescaler, count register and wrap pulse; CLR outranks a coincident step
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            step_cnt_r <= '0;
            value_r    <= '0;
            wrap_r     <= 1'b0;
        end else if (CLR) begin
            step_cnt_r <= '0;
            value_r    <= '0;
            wrap_r     <= 1'b0;
        end else if (step_s) begin
            step_cnt_r <= '0;
            value_r    <= value_nx_s;
            wrap_r     <= carry_s;
        end else if (EN) begin
            step_cnt_r <= step_cnt_r + SW'(1);
            wrap_r     <= 1'b0;
        end else begin
            wrap_r     <= 1'b0;
        end
    end

    // free-running scan prescaler and digit index
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            scan_cnt_r <= '0;
            idx_r      <= '0;
        end else if (scan_cnt_r == CW'(SCAN_CYC - 1)) begin
            scan_cnt_r <= '0;
            idx_r      <= (idx_r == IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
        end
    end

    // select the scanned nibble, anode and dot
    always_comb begin
        nib_s   = '0;
        anode_s = '1;
        dp_s    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IW'(i)) begin
                nib_s      = value_r[i*NW +: NW];
                anode_s[i] = 1'b0;
                dp_s       = ~DP_MASK[i];
            end else begin
                anode_s[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .bcd (nib_s),
        .seg (dec_s)
    );

`ifdef SEG7_LZB_EN
    logic zero_acc_s;

    // blank a digit above position 0 when it and every higher nibble are zero
    always_comb begin
        zero_acc_s = 1'b1;
        blank_s    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc_s = zero_acc_s && (value_r[i*NW +: NW] == 4'd0);
            blank_s    = blank_s || (zero_acc_s && (idx_r == IW'(i)) && (i > 32'sd0));
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    assign seg_s = blank_s ? SEG_BLANK : dec_s;

    // registered pin drive; all ones keeps every digit dark
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            disp_r <= '1;
        end else begin
            disp_r <= {anode_s, seg_s, dp_s};
        end
    end

    assign VALUE = value_r;
    assign WRAP  = wrap_r;
    assign DISP  = disp_r;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench: three counter instances (4, 2 and 1 digits) compared
// every cycle against a decimal-arithmetic model, plus directed scan tables.
module tb_seg7_scan_counter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST_N, EN, UP, CLR;
    logic [3:0] DP_MASK;

    logic [15:0] VALUE_A; logic WRAP_A; logic [11:0] DISP_A;
    logic [7:0]  VALUE_B; logic WRAP_B; logic [9:0]  DISP_B;
    logic [3:0]  VALUE_C; logic WRAP_C; logic [8:0]  DISP_C;

    seg7_scan_counter #(.DIGITS(4), .STEP_CYC(4), .SCAN_CYC(3)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .CLR(CLR),
        .DP_MASK(DP_MASK), .VALUE(VALUE_A), .WRAP(WRAP_A), .DISP(DISP_A));
    seg7_scan_counter #(.DIGITS(2), .STEP_CYC(4), .SCAN_CYC(5)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .CLR(CLR),
        .DP_MASK(DP_MASK[1:0]), .VALUE(VALUE_B), .WRAP(WRAP_B), .DISP(DISP_B));
    seg7_scan_counter #(.DIGITS(1), .STEP_CYC(2), .SCAN_CYC(2)) dut_c (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .CLR(CLR),
        .DP_MASK(DP_MASK[0:0]), .VALUE(VALUE_C), .WRAP(WRAP_C), .DISP(DISP_C));

    int n_checks = 0;
    int n_fail   = 0;

    localparam int NI = 3;
    localparam int PD [NI] = '{4, 2, 1};
    localparam int PS [NI] = '{4, 4, 2};
    localparam int PC [NI] = '{3, 5, 2};

    int          m_val   [NI];
    int          m_presc [NI];
    int          m_scan  [NI];
    int          m_idx   [NI];
    logic        m_wrap  [NI];
    logic [15:0] m_disp  [NI];

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpm;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } row_t;
    row_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int p10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [15:0] exp_disp(input int n, input int v, input int idx, input logic [3:0] dp);
        logic [15:0] r = '0;
        logic [6:0]  s;
        s = seg_of((v / p10(idx)) % 10);
`ifdef SEG7_LZB_EN
        if (idx > 0 && v < p10(idx)) s = 7'b1111111;
`endif
        for (int i = 0; i < PD[n]; i++) r[8+i] = (i != idx);
        r[7:1] = s;
        r[0]   = ~dp[idx];
        return r;
    endfunction

    task automatic model_step(input int n);
        int top;
        top = p10(PD[n]);
        if (!RST_N) begin
            m_val[n] = 0; m_presc[n] = 0; m_scan[n] = 0; m_idx[n] = 0; m_wrap[n] = 1'b0;
            m_disp[n] = '0;
            for (int i = 0; i < PD[n] + 8; i++) m_disp[n][i] = 1'b1;
        end else begin
            m_disp[n] = exp_disp(n, m_val[n], m_idx[n], DP_MASK);
            if (m_scan[n] == PC[n] - 1) begin
                m_scan[n] = 0;
                m_idx[n]  = (m_idx[n] + 1) % PD[n];
            end else begin
                m_scan[n]++;
            end
            if (CLR) begin
                m_val[n] = 0; m_presc[n] = 0; m_wrap[n] = 1'b0;
            end else if (EN && m_presc[n] == PS[n] - 1) begin
                m_presc[n] = 0;
                if (UP) begin
                    m_wrap[n] = (m_val[n] == top - 1);
                    m_val[n]  = (m_val[n] + 1) % top;
                end else begin
                    m_wrap[n] = (m_val[n] == 0);
                    m_val[n]  = (m_val[n] + top - 1) % top;
                end
            end else begin
                if (EN) m_presc[n]++;
                m_wrap[n] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] act_val(input int n);
        case (n)
            0:       return {16'h0, VALUE_A};
            1:       return {24'h0, VALUE_B};
            default: return {28'h0, VALUE_C};
        endcase
    endfunction

    function automatic logic [31:0] act_disp(input int n);
        case (n)
            0:       return {20'h0, DISP_A};
            1:       return {22'h0, DISP_B};
            default: return {23'h0, DISP_C};
        endcase
    endfunction

    function automatic logic act_wrap(input int n);
        case (n)
            0:       return WRAP_A;
            1:       return WRAP_B;
            default: return WRAP_C;
        endcase
    endfunction

    task automatic cycle();
        @(posedge CLK);
        for (int n = 0; n < NI; n++) model_step(n);
        #1;
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("model_value[%0d]", n), act_val(n), to_bcd(m_val[n], PD[n]));
            chk($sformatf("model_wrap[%0d]", n), {31'h0, act_wrap(n)}, {31'h0, m_wrap[n]});
            chk($sformatf("model_disp[%0d]", n), act_disp(n), {16'h0, m_disp[n]});
        end
    endtask

    task automatic scan_check(input int base, input string name);
        logic [3:0] prev;
        bit         found = 1'b0;
        row_t       r;
        for (int k = 0; k < 20 && !found; k++) begin
            prev = DISP_A[11:8];
            cycle();
            if (prev != 4'b1110 && DISP_A[11:8] == 4'b1110) found = 1'b1;
        end
        chk({name, "_sync"}, {31'h0, found}, 32'h1);
        for (int j = 0; j <= 12; j++) begin
            r = tbl[base + (j / 3) % 4];
            chk({name, "_value"}, {16'h0, VALUE_A}, {16'h0, r.value});
            chk({name, "_disp"}, {20'h0, DISP_A}, {20'h0, r.an, r.seg, r.dp});
            cycle();
        end
    endtask

    initial begin
        int         wraps;
        logic [6:0] lz;
`ifdef SEG7_LZB_EN
        lz = 7'b1111111;
`else
        lz = 7'b0000001;
`endif
        tbl[0]  = '{16'h1234, 4'b0100, 4'b1110, 7'b1001100, 1'b1};
        tbl[1]  = '{16'h1234, 4'b0100, 4'b1101, 7'b0000110, 1'b1};
        tbl[2]  = '{16'h1234, 4'b0100, 4'b1011, 7'b0010010, 1'b0};
        tbl[3]  = '{16'h1234, 4'b0100, 4'b0111, 7'b1001111, 1'b1};
        tbl[4]  = '{16'h0007, 4'b0100, 4'b1110, 7'b0001111, 1'b1};
        tbl[5]  = '{16'h0007, 4'b0100, 4'b1101, lz,         1'b1};
        tbl[6]  = '{16'h0007, 4'b0100, 4'b1011, lz,         1'b0};
        tbl[7]  = '{16'h0007, 4'b0100, 4'b0111, lz,         1'b1};
        tbl[8]  = '{16'h0000, 4'b0100, 4'b1110, 7'b0000001, 1'b1};
        tbl[9]  = '{16'h0000, 4'b0100, 4'b1101, lz,         1'b1};
        tbl[10] = '{16'h0000, 4'b0100, 4'b1011, lz,         1'b0};
        tbl[11] = '{16'h0000, 4'b0100, 4'b0111, lz,         1'b1};

        RST_N = 1'b0; EN = 1'b1; UP = 1'b1; CLR = 1'b0; DP_MASK = 4'b0000;
        repeat (3) cycle();
        chk("rst_value", {16'h0, VALUE_A}, 32'h0);
        chk("rst_wrap", {31'h0, WRAP_A}, 32'h0);
        chk("rst_disp", {20'h0, DISP_A}, 32'hfff);

        // up count over 100 steps: the 2-digit instance wraps once
        RST_N = 1'b1;
        wraps = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (i == 0) chk("first_disp", {20'h0, DISP_A}, 32'he03);
            if (WRAP_B) wraps++;
        end
        chk("upwrap_pulses", wraps, 32'd1);
        chk("upwrap_value_b", {24'h0, VALUE_B}, 32'h00);
        chk("upwrap_flag_b", {31'h0, WRAP_B}, 32'h1);
        chk("up_value_a", {16'h0, VALUE_A}, 32'h0100);

        // underflow 00 -> 99, then 98
        UP = 1'b0;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 3) begin
                chk("under_value_b", {24'h0, VALUE_B}, 32'h99);
                chk("under_flag_b", {31'h0, WRAP_B}, 32'h1);
            end
            if (WRAP_B) wraps++;
        end
        chk("under_pulses", wraps, 32'd1);
        chk("under_next_b", {24'h0, VALUE_B}, 32'h98);
        chk("down_value_a", {16'h0, VALUE_A}, 32'h0098);

        // clear coincident with a step at value 41
        repeat (228) cycle();
        chk("pre_clr_a", {16'h0, VALUE_A}, 32'h0041);
        chk("pre_clr_b", {24'h0, VALUE_B}, 32'h41);
        repeat (3) cycle();
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        chk("clr_value_a", {16'h0, VALUE_A}, 32'h0);
        chk("clr_wrap_a", {31'h0, WRAP_A}, 32'h0);
        chk("clr_value_b", {24'h0, VALUE_B}, 32'h0);

        // enable hold mid-prescale
        UP = 1'b1;
        repeat (2) cycle();
        EN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("hold_value", {16'h0, VALUE_A}, 32'h0);
        end
        EN = 1'b1;
        cycle();
        chk("resume_wait", {16'h0, VALUE_A}, 32'h0);
        cycle();
        chk("resume_step", {16'h0, VALUE_A}, 32'h1);

        // reach 1234 and check the scan sequence
        repeat (4932) cycle();
        chk("reach_1234", {16'h0, VALUE_A}, 32'h1234);
        EN = 1'b0;
        DP_MASK = 4'b0100;
        scan_check(0, "scan1234");

        // leading zeros: 0007, then 0000
        CLR = 1'b1; cycle(); CLR = 1'b0;
        EN = 1'b1;
        repeat (28) cycle();
        EN = 1'b0;
        scan_check(4, "scan0007");
        CLR = 1'b1; cycle(); CLR = 1'b0;
        scan_check(8, "scan0000");

        // reset in the middle of a step and a scan dwell
        EN = 1'b1;
        repeat (6) cycle();
        RST_N = 1'b0;
        cycle();
        chk("midrst_value", {16'h0, VALUE_A}, 32'h0);
        chk("midrst_disp", {20'h0, DISP_A}, 32'hfff);
        RST_N = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RST_N   = ($urandom_range(0, 299) != 0);
            EN      = ($urandom_range(0, 3) != 0);
            UP      = ($urandom_range(0, 3) != 0);
            CLR     = ($urandom_range(0, 99) == 0);
            DP_MASK = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
